// File: rtl/mm_tile_scheduler.sv
// rtl/mm_tile_scheduler.sv - splits an M*K*T x K*N*T job into T tiles and feeds matrix_multiplier
// Optional watchdog on the wait states: define MM_SCHED_WDOG_EN.
`ifndef WIDTH_DATA
`define WIDTH_DATA 16
`endif

module mm_tile_scheduler #(
  parameter int M          = 4,
  parameter int K          = 3,
  parameter int N          = 3,
  parameter int WIDTH_TILE = 4,
  parameter int SRC_AW     = 16,
  parameter int WDOG_CYC   = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [WIDTH_TILE-1:0]              cmd_tile_num,
  input  logic [SRC_AW-1:0]                  cmd_w_base,
  input  logic [SRC_AW-1:0]                  cmd_fm_base,
  input  logic                               abort,
  output logic                               src_rd_en,
  output logic [SRC_AW-1:0]                  src_rd_addr,
  input  logic [`WIDTH_DATA-1:0]             src_rd_data,
  output logic                               mm_w_en,
  output logic [((K*N > 1) ? $clog2(K*N) : 1)-1:0] mm_w_addr,
  output logic [`WIDTH_DATA-1:0]             mm_w_in,
  output logic                               mm_fm_en,
  output logic [((M*K > 1) ? $clog2(M*K) : 1)-1:0] mm_fm_addr,
  output logic [`WIDTH_DATA-1:0]             mm_fm_in,
  output logic                               mm_start,
  output logic [WIDTH_TILE-1:0]              mm_tile_num,
  input  logic                               mm_result_valid,
  input  logic                               mm_acc_valid,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH_TILE-1:0]              tile_idx,
  output logic                               err
);

  localparam int KN      = K * N;
  localparam int MK      = M * K;
  localparam int WA_W    = (KN > 1) ? $clog2(KN) : 1;
  localparam int FA_W    = (MK > 1) ? $clog2(MK) : 1;
  localparam int CNT_MAX = (KN > MK) ? KN : MK;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_FM, DRAIN, START, WAIT_T, WAIT_ACC, DONE
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt;
  logic [WIDTH_TILE-1:0] t_q, tile_num_q;
  logic [SRC_AW-1:0]     w_base_q, fm_base_q, w_off, fm_off;
  logic                  w_en_q, fm_en_q;
  logic [WA_W-1:0]       w_addr_q;
  logic [FA_W-1:0]       fm_addr_q;
  logic                  accept, abort_hit, tile_adv, wdog_hit, wdog_trip;

  always_comb begin
    state_next = state;
    tile_adv   = 1'b0;
    wdog_trip  = 1'b0;
    accept     = 1'b0;
    abort_hit  = abort && (state != IDLE);
    case (state)
      IDLE: begin
        if (cmd_valid && !abort) begin
          accept     = 1'b1;
          state_next = (cmd_tile_num == '0) ? DONE : LOAD_W;
        end
      end
      LOAD_W:  if (cnt == CW'(KN - 1)) state_next = LOAD_FM;
      LOAD_FM: if (cnt == CW'(MK - 1)) state_next = DRAIN;
      DRAIN:   state_next = START;
      START:   state_next = WAIT_T;
      WAIT_T: begin
        if (mm_result_valid) begin
          if (t_q != tile_num_q - WIDTH_TILE'(1)) begin
            tile_adv   = 1'b1;
            state_next = LOAD_W;
          end else if (mm_acc_valid) begin
            state_next = DONE;
          end else begin
            state_next = WAIT_ACC;
          end
        end else if (wdog_hit) begin
          wdog_trip  = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_ACC: begin
        if (mm_acc_valid) begin
          state_next = DONE;
        end else if (wdog_hit) begin
          wdog_trip  = 1'b1;
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // abort overrides every other event, including a watchdog expiry
    if (abort_hit) begin
      state_next = IDLE;
      tile_adv   = 1'b0;
      wdog_trip  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      t_q        <= '0;
      tile_num_q <= '0;
      w_base_q   <= '0;
      fm_base_q  <= '0;
      w_off      <= '0;
      fm_off     <= '0;
      w_en_q     <= 1'b0;
      fm_en_q    <= 1'b0;
      w_addr_q   <= '0;
      fm_addr_q  <= '0;
    end else begin
      state <= state_next;
      if ((state_next == state) && ((state == LOAD_W) || (state == LOAD_FM)))
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      // write port trails the read strobe by one cycle to meet the RAM latency
      w_en_q    <= (state == LOAD_W) && !abort_hit;
      fm_en_q   <= (state == LOAD_FM) && !abort_hit;
      w_addr_q  <= WA_W'(cnt);
      fm_addr_q <= FA_W'(cnt);
      if (accept) begin
        tile_num_q <= cmd_tile_num;
        w_base_q   <= cmd_w_base;
        fm_base_q  <= cmd_fm_base;
        t_q        <= '0;
        w_off      <= '0;
        fm_off     <= '0;
      end else if (tile_adv) begin
        t_q    <= t_q + WIDTH_TILE'(1);
        w_off  <= w_off + SRC_AW'(KN);
        fm_off <= fm_off + SRC_AW'(MK);
      end else if (state_next == IDLE) begin
        t_q <= '0;
      end
    end
  end

`ifdef MM_SCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wdog_cnt;
  logic           err_q;

  assign wdog_hit = (wdog_cnt == WDW'(WDOG_CYC - 1));
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_next != state) || !((state == WAIT_T) || (state == WAIT_ACC)))
        wdog_cnt <= '0;
      else
        wdog_cnt <= wdog_cnt + WDW'(1);
      if (accept)
        err_q <= 1'b0;
      else if (wdog_trip)
        err_q <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign err      = 1'b0;
`endif

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign mm_start    = (state == START);
  assign mm_tile_num = tile_num_q;
  assign tile_idx    = t_q;
  assign src_rd_en   = (state == LOAD_W) || (state == LOAD_FM);

  always_comb begin
    src_rd_addr = '0;
    if (state == LOAD_W)
      src_rd_addr = w_base_q + w_off + SRC_AW'(cnt);
    else if (state == LOAD_FM)
      src_rd_addr = fm_base_q + fm_off + SRC_AW'(cnt);
  end

  assign mm_w_en    = w_en_q;
  assign mm_w_addr  = w_addr_q;
  assign mm_w_in    = w_en_q ? src_rd_data : '0;
  assign mm_fm_en   = fm_en_q;
  assign mm_fm_addr = fm_addr_q;
  assign mm_fm_in   = fm_en_q ? src_rd_data : '0;

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// tb/tb_mm_tile_scheduler.sv - directed self-checking bench for mm_tile_scheduler
// Wrapping source RAM model returns addr ^ 0x5A3C one cycle after each read strobe.
`timescale 1ns/1ps

module tb_mm_tile_scheduler;
  localparam int M = 4, K = 3, N = 3, WT = 4, AW = 16, DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [WT-1:0] cmd_tile_num = '0;
  logic [AW-1:0] cmd_w_base = '0, cmd_fm_base = '0;
  logic          abort = 1'b0;
  logic          src_rd_en;
  logic [AW-1:0] src_rd_addr;
  logic [DW-1:0] src_rd_data = '0;
  logic          mm_w_en, mm_fm_en, mm_start;
  logic [3:0]    mm_w_addr, mm_fm_addr;
  logic [DW-1:0] mm_w_in, mm_fm_in;
  logic [WT-1:0] mm_tile_num, tile_idx;
  logic          mm_result_valid = 1'b0, mm_acc_valid = 1'b0;
  logic          busy, done, err;

  int n_checks = 0, n_errors = 0;
  int n_start = 0, n_done = 0;
  int first_start, done_cyc, acc_cyc;
  logic [AW-1:0] rd_log[$];
  logic [3:0]    w_addr_log[$], fm_addr_log[$], idx_log[$];
  logic [DW-1:0] w_data_log[$], fm_data_log[$];

  mm_tile_scheduler #(.M(M), .K(K), .N(N), .WIDTH_TILE(WT), .SRC_AW(AW), .WDOG_CYC(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tile_num(cmd_tile_num), .cmd_w_base(cmd_w_base), .cmd_fm_base(cmd_fm_base),
    .abort(abort), .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .mm_w_en(mm_w_en), .mm_w_addr(mm_w_addr), .mm_w_in(mm_w_in),
    .mm_fm_en(mm_fm_en), .mm_fm_addr(mm_fm_addr), .mm_fm_in(mm_fm_in),
    .mm_start(mm_start), .mm_tile_num(mm_tile_num), .mm_result_valid(mm_result_valid),
    .mm_acc_valid(mm_acc_valid), .busy(busy), .done(done), .tile_idx(tile_idx), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram(input logic [AW-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  always @(posedge clk) if (src_rd_en) src_rd_data <= ram(src_rd_addr);

  always @(negedge clk) begin
    if (src_rd_en) rd_log.push_back(src_rd_addr);
    if (mm_w_en) begin w_addr_log.push_back(mm_w_addr); w_data_log.push_back(mm_w_in); end
    if (mm_fm_en) begin fm_addr_log.push_back(mm_fm_addr); fm_data_log.push_back(mm_fm_in); end
    if (mm_start) begin n_start++; idx_log.push_back(tile_idx); end
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); w_addr_log.delete(); w_data_log.delete();
    fm_addr_log.delete(); fm_data_log.delete(); idx_log.delete();
    n_start = 0; n_done = 0;
  endtask

  task automatic issue(input int tn, input logic [AW-1:0] wb, input logic [AW-1:0] fb);
    @(negedge clk);
    clear_logs();
    cmd_tile_num = WT'(tn); cmd_w_base = wb; cmd_fm_base = fb; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Plays the multiplier: result_valid lat cycles after each start, acc_valid 2 cycles later
  task automatic run_job(input int tn, input logic [AW-1:0] wb, input logic [AW-1:0] fb,
                         input int lat, input bit both);
    int cyc, wait_cnt, tiles, acc_cnt;
    bit waiting;
    waiting = 0; tiles = 0; acc_cnt = 0;
    first_start = -1; done_cyc = -1; acc_cyc = -1;
    issue(tn, wb, fb);
    cyc = 1;
    while (cyc < 3000) begin
      mm_result_valid = 1'b0; mm_acc_valid = 1'b0;
      if (done) begin done_cyc = cyc; break; end
      if (mm_start) begin
        if (first_start < 0) first_start = cyc;
        wait_cnt = 0; waiting = 1;
      end else if (waiting) begin
        wait_cnt++;
        if (wait_cnt == lat) begin
          mm_result_valid = 1'b1; waiting = 0; tiles++;
          if (tiles == tn) begin
            if (both) begin mm_acc_valid = 1'b1; acc_cyc = cyc; end
            else acc_cnt = 1;
          end
        end
      end else if (acc_cnt > 0) begin
        acc_cnt++;
        if (acc_cnt == 3) begin mm_acc_valid = 1'b1; acc_cyc = cyc; acc_cnt = 0; end
      end
      @(negedge clk); cyc++;
    end
    mm_result_valid = 1'b0; mm_acc_valid = 1'b0;
    check("job_done_seen", (done_cyc > 0), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_job(input string tag, input int tn, input logic [AW-1:0] wb,
                           input logic [AW-1:0] fb);
    int r;
    logic [AW-1:0] a;
    check({tag, "_rd_cnt"}, rd_log.size(), tn * (K*N + M*K));
    check({tag, "_w_cnt"}, w_addr_log.size(), tn * K*N);
    check({tag, "_fm_cnt"}, fm_addr_log.size(), tn * M*K);
    check({tag, "_starts"}, n_start, tn);
    check({tag, "_dones"}, n_done, 1);
    if (rd_log.size() != tn * (K*N + M*K) || w_addr_log.size() != tn*K*N ||
        fm_addr_log.size() != tn*M*K) return;
    r = 0;
    for (int t = 0; t < tn; t++) begin
      for (int i = 0; i < K*N; i++) begin
        a = wb + AW'(t*K*N + i);
        check({tag, "_w_rd"}, rd_log[r], a); r++;
        check({tag, "_w_addr"}, w_addr_log[t*K*N + i], i);
        check({tag, "_w_data"}, w_data_log[t*K*N + i], ram(a));
      end
      for (int j = 0; j < M*K; j++) begin
        a = fb + AW'(t*M*K + j);
        check({tag, "_fm_rd"}, rd_log[r], a); r++;
        check({tag, "_fm_addr"}, fm_addr_log[t*M*K + j], j);
        check({tag, "_fm_data"}, fm_data_log[t*M*K + j], ram(a));
      end
    end
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {src_rd_en, mm_w_en, mm_fm_en, mm_start}, 4'b0);
    check("rst_err", err, 0);
    check("rst_tile", {tile_idx, mm_tile_num}, 8'h00);
    rst = 1'b0;

    // stray valids while idle are ignored
    @(negedge clk); mm_result_valid = 1'b1; mm_acc_valid = 1'b1;
    @(negedge clk); mm_result_valid = 1'b0; mm_acc_valid = 1'b0;
    check("idle_valid_busy", busy, 0);
    check("idle_valid_done", done, 0);

    // single tile
    run_job(1, 16'h0010, 16'h0040, 20, 0);
    check_job("t1", 1, 16'h0010, 16'h0040);
    check("t1_start_lat", first_start, K*N + M*K + 2);
    check("t1_done_after_acc", done_cyc - acc_cyc, 1);
    check("t1_idle", {busy, cmd_ready}, 2'b01);

    // three tiles
    run_job(3, 16'h0000, 16'h0100, 5, 0);
    check_job("t3", 3, 16'h0000, 16'h0100);
    if (idx_log.size() == 3)
      for (int i = 0; i < 3; i++) check("t3_tile_idx", idx_log[i], i);
    else check("t3_idx_cnt", idx_log.size(), 3);
    check("t3_tile_num", mm_tile_num, 3);
    check("t3_done_after_acc", done_cyc - acc_cyc, 1);

    // zero tiles
    run_job(0, 16'h0200, 16'h0300, 5, 0);
    check("t0_done_cyc", done_cyc, 1);
    check("t0_reads", rd_log.size(), 0);
    check("t0_starts", n_start, 0);
    check("t0_dones", n_done, 1);

    // address wrap, result and acc valid together on the last tile
    run_job(1, 16'hFFFC, 16'hFFF8, 3, 1);
    check_job("wrap", 1, 16'hFFFC, 16'hFFF8);
    check("wrap_both_done", done_cyc - acc_cyc, 1);

    // abort in LOAD_FM
    issue(2, 16'h0000, 16'h0080);
    repeat (12) @(negedge clk);
    check("ab_in_fm", {src_rd_en, busy}, 2'b11);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("ab_idle", {busy, cmd_ready}, 2'b01);
    check("ab_strobes", {src_rd_en, mm_w_en, mm_fm_en, mm_start}, 4'b0);
    // command offered together with abort in IDLE is refused
    cmd_tile_num = 4'd1; cmd_valid = 1'b1; abort = 1'b1;
    @(negedge clk); cmd_valid = 1'b0; abort = 1'b0;
    check("ab_idle_no_accept", busy, 0);

    // reset in WAIT_T
    issue(1, 16'h0000, 16'h0080);
    cnt = 0;
    while (!mm_start && cnt < 100) begin @(negedge clk); cnt++; end
    check("rs_start_seen", mm_start, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rs_idle", {busy, cmd_ready}, 2'b01);
    check("rs_strobes", {src_rd_en, mm_w_en, mm_fm_en, mm_start}, 4'b0);
    check("rs_tile", {tile_idx, mm_tile_num}, 8'h00);
    repeat (5) @(negedge clk);
    check("ab_rs_no_done", n_done, 0);

    run_job(2, 16'h0500, 16'h0600, 4, 0);
    check_job("post", 2, 16'h0500, 16'h0600);

`ifdef MM_SCHED_WDOG_EN
    issue(1, 16'h0000, 16'h0080);
    cnt = 0;
    while (!mm_start && cnt < 100) begin @(negedge clk); cnt++; end
    check("wd_start_seen", mm_start, 1);
    cnt = 0;
    while (!err && cnt < 50) begin @(negedge clk); cnt++; end
    check("wd_err", err, 1);
    check("wd_delay", cnt, 9);
    check("wd_idle", busy, 0);
    check("wd_no_done", n_done, 0);
    issue(0, 16'h0000, 16'h0000);
    check("wd_err_clear", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end
endmodule
